// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
//
// Double-buffered 8x8 RGB LED matrix column scanner. The producer fills the
// back bank one column at a time and requests a swap. The banks flip only at
// the frame boundary (terminal count of column 7). The front bank is then
// multiplexed onto the active-low DATA_R/G/B row lines, with COMM selecting
// the column.
//
// Optional feature (compile-time macro MATRIX_BLANK_EN):
//   When defined, DATA_* is forced to 8'hFF for the first BLANK_CYCLES cycles
//   of every column. When undefined, front data is driven for the whole column.
//
// Parameters:
//   SCAN_DIV      CLK cycles per column (2..65535)
//   BLANK_CYCLES  dark cycles at the start of each column (< SCAN_DIV),
//                 used only with MATRIX_BLANK_EN
//
// Ports:
//   CLK, ResetN          clock, asynchronous active-low reset
//   wr_en, wr_col        back-bank column write strobe and column index
//   wr_r, wr_g, wr_b     active-low pixel bytes, bit n = row n
//   swap_req             request to present the back bank (coalescing)
//   swap_ack             pulse in the cycle the banks flip
//   frame_start          pulse in the cycle COMM goes from 7 to 0
//   DATA_R/G/B           registered active-low row drive
//   COMM                 registered active column
//   enable               driver enable, high from the first edge after reset

module led_matrix_scanner #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic       CLK,
    input  logic       ResetN,
    input  logic       wr_en,
    input  logic [2:0] wr_col,
    input  logic [7:0] wr_r,
    input  logic [7:0] wr_g,
    input  logic [7:0] wr_b,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       frame_start,
    output logic [7:0] DATA_R,
    output logic [7:0] DATA_G,
    output logic [7:0] DATA_B,
    output logic [2:0] COMM,
    output logic       enable
);

`ifdef MATRIX_BLANK_EN
    localparam bit BlankEn = 1'b1;
`else
    localparam bit BlankEn = 1'b0;
`endif

    if (SCAN_DIV < 2 || SCAN_DIV > 65535 || (BlankEn && BLANK_CYCLES >= SCAN_DIV)) begin : g_bad_cfg
        $error("led_matrix_scanner: invalid SCAN_DIV / BLANK_CYCLES");
    end

    localparam logic [15:0] DivLast = 16'(SCAN_DIV - 1);
`ifdef MATRIX_BLANK_EN
    localparam logic [15:0] BlankLen = 16'(BLANK_CYCLES);
`endif

    // Two banks of 8 columns, each {R, G, B}.
    logic [23:0] bank_q [2][8];

    logic [15:0] div_q, div_d;
    logic [2:0]  col_q, col_d;
    logic        front_q, front_d;
    logic        pending_q, pending_d;
    logic [23:0] data_q, data_d;
    logic        ack_q, ack_d;
    logic        frame_start_q, frame_start_d;
    logic        enable_q;

    logic        tc;
    logic        flip;
    logic [23:0] pix;

    always_comb begin
        tc        = (div_q == DivLast);
        flip      = tc && (col_q == 3'd7) && pending_q;
        div_d     = tc ? 16'd0 : div_q + 16'd1;
        col_d     = tc ? col_q + 3'd1 : col_q;
        front_d   = front_q ^ flip;
        // A request in the flip cycle re-arms pending for the next boundary.
        pending_d = swap_req | (pending_q & ~flip);

        // Both pulses are registered, so predict the terminal cycle of column 7.
        frame_start_d = (div_d == DivLast) && (col_d == 3'd7);
        ack_d         = frame_start_d && pending_d;

        pix = bank_q[front_d][col_d];
        // A write in the flip cycle lands in the bank about to become front;
        // forward it so the new column 0 never shows the stale word.
        if (wr_en && flip && (wr_col == col_d)) begin
            pix = {wr_r, wr_g, wr_b};
        end

`ifdef MATRIX_BLANK_EN
        data_d = (div_d < BlankLen) ? 24'hFF_FFFF : pix;
`else
        data_d = pix;
`endif
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < 8; c++) begin
                    bank_q[b][c] <= 24'hFF_FFFF;
                end
            end
        end else if (wr_en) begin
            // Writes always target the bank that is back in this cycle.
            bank_q[~front_q][wr_col] <= {wr_r, wr_g, wr_b};
        end
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            div_q         <= 16'd0;
            col_q         <= 3'd0;
            front_q       <= 1'b0;
            pending_q     <= 1'b0;
            data_q        <= 24'hFF_FFFF;
            ack_q         <= 1'b0;
            frame_start_q <= 1'b0;
            enable_q      <= 1'b0;
        end else begin
            div_q         <= div_d;
            col_q         <= col_d;
            front_q       <= front_d;
            pending_q     <= pending_d;
            data_q        <= data_d;
            ack_q         <= ack_d;
            frame_start_q <= frame_start_d;
            enable_q      <= 1'b1;
        end
    end

    assign DATA_R      = data_q[23:16];
    assign DATA_G      = data_q[15:8];
    assign DATA_B      = data_q[7:0];
    assign COMM        = col_q;
    assign swap_ack    = ack_q;
    assign frame_start = frame_start_q;
    assign enable      = enable_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Testbench for led_matrix_scanner with SCAN_DIV=8, BLANK_CYCLES=3.
// Every output is packed as {enable, swap_ack, frame_start, COMM, R, G, B} and
// compared each cycle against the expectation queued when the cycle's stimulus
// was applied.

module tb_led_matrix_scanner;

    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 3;
    localparam int FRAME        = 8 * SCAN_DIV;

    logic       CLK = 1'b0;
    logic       ResetN = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_col = 3'd0;
    logic [7:0] wr_r = 8'hFF;
    logic [7:0] wr_g = 8'hFF;
    logic [7:0] wr_b = 8'hFF;
    logic       swap_req = 1'b0;
    logic       swap_ack;
    logic       frame_start;
    logic [7:0] DATA_R;
    logic [7:0] DATA_G;
    logic [7:0] DATA_B;
    logic [2:0] COMM;
    logic       enable;

    led_matrix_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .CLK        (CLK),
        .ResetN     (ResetN),
        .wr_en      (wr_en),
        .wr_col     (wr_col),
        .wr_r       (wr_r),
        .wr_g       (wr_g),
        .wr_b       (wr_b),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .frame_start(frame_start),
        .DATA_R     (DATA_R),
        .DATA_G     (DATA_G),
        .DATA_B     (DATA_B),
        .COMM       (COMM),
        .enable     (enable)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [29:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  tests = 0;
    int  fails = 0;

    // Reference state: cycles since reset release, banks, front pointer,
    // pending swap and the cycle in which its ack is due.
    int          phase;
    logic [23:0] m_bank [2][8];
    logic        m_front;
    logic        m_pend;
    logic        m_en;
    int          m_ack_phase;

    localparam logic [29:0] ResetExp = {1'b0, 1'b0, 1'b0, 3'd0, 24'hFF_FFFF};

    function automatic logic [29:0] pack_obs();
        return {enable, swap_ack, frame_start, COMM, DATA_R, DATA_G, DATA_B};
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 8; c++) begin
                m_bank[b][c] = 24'hFF_FFFF;
            end
        end
        m_front     = 1'b0;
        m_pend      = 1'b0;
        m_ack_phase = -1;
        phase       = 0;
    endfunction

    function automatic logic [29:0] model_out(input int p);
        int          d;
        int          c;
        logic [23:0] px;
        logic        ack;
        logic        fs;
        d  = p % SCAN_DIV;
        c  = (p / SCAN_DIV) % 8;
        px = m_bank[m_front][c];
`ifdef MATRIX_BLANK_EN
        if (d < BLANK_CYCLES) px = 24'hFF_FFFF;
`else
        if (d < 0) px = 24'h00_0000;
`endif
        ack = m_pend && (p == m_ack_phase);
        fs  = ((p % FRAME) == FRAME - 1);
        return {m_en, ack, fs, 3'(c), px};
    endfunction

    task automatic check_head();
        sb_t         e;
        logic [29:0] obs;
        e   = sb_q.pop_front();
        obs = pack_obs();
        tests++;
        assert (obs === e.exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [29:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Apply the current inputs to the model, queue the expectation for the
    // next cycle, advance one clock and compare.
    task automatic step(input string tag);
        if (wr_en) m_bank[!m_front][wr_col] = {wr_r, wr_g, wr_b};
        if (m_pend && phase == m_ack_phase) begin
            m_front = !m_front;
            m_pend  = 1'b0;
        end
        if (swap_req && !m_pend) begin
            m_pend      = 1'b1;
            m_ack_phase = phase - (phase % FRAME) + FRAME - 1;
            if (m_ack_phase <= phase) m_ack_phase += FRAME;
        end
        push_exp($sformatf("%s@%0d", tag, phase + 1), model_out(phase + 1));
        @(negedge CLK);
        phase++;
        wr_en    = 1'b0;
        swap_req = 1'b0;
        check_head();
    endtask

    task automatic run_to(input int target, input string tag);
        while (phase < target) step(tag);
    endtask

    task automatic release_reset();
        ResetN = 1'b1;
        model_reset();
        m_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        m_en = 1'b0;
        model_reset();

        // Reset held for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            push_exp($sformatf("reset%0d", i), ResetExp);
            @(negedge CLK);
            check_head();
        end
        release_reset();

        // One dark frame: COMM stepping, frame_start, enable.
        run_to(FRAME, "scan");

        // Write column 3, then request a swap.
        wr_en = 1'b1; wr_col = 3'd3; wr_r = 8'h0F; wr_g = 8'hF0; wr_b = 8'hAA;
        step("wr3");
        swap_req = 1'b1;
        step("swap1");
        run_to(200, "show3");

        // Three coalesced requests, then one in the ack cycle.
        swap_req = 1'b1;
        step("coal_a");
        run_to(203, "coal");
        swap_req = 1'b1;
        step("coal_b");
        run_to(210, "coal");
        swap_req = 1'b1;
        step("coal_c");
        run_to(4 * FRAME - 1, "coal");
        swap_req = 1'b1;
        step("req_in_ack");
        run_to(330, "second_ack");

        // Write column 0 in the flip cycle.
        swap_req = 1'b1;
        step("swap3");
        run_to(6 * FRAME - 1, "pre_collide");
        wr_en = 1'b1; wr_col = 3'd0; wr_r = 8'h00; wr_g = 8'hFF; wr_b = 8'hFF;
        step("collide");
        run_to(460, "post_collide");

        // Pending swap lost to a reset while COMM = 5.
        swap_req = 1'b1;
        step("swap4");
        run_to(7 * FRAME + 5 * SCAN_DIV + 2, "to_col5");
        ResetN = 1'b0;
        #1;
        push_exp("midreset_async", ResetExp);
        check_head();
        for (int i = 0; i < 3; i++) begin
            push_exp($sformatf("midreset%0d", i), ResetExp);
            @(negedge CLK);
            check_head();
        end
        release_reset();
        run_to(FRAME + 16, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
